// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle for the multi-cycle MIPS controller.
// master = controller side, slave = datapath/memory side.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [2:0] alucon;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;

    modport master (
        input  op, funct, zero, mem_ready,
        output alucon, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_src,
               ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg
    );
    modport slave (
        output op, funct, zero, mem_ready,
        input  alucon, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_src,
               ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-timeout fault and sticky HALT.
// Optional MIPSCTL_PERF_EN adds instr_retired / cycle_count counters.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mips_multicycle_ctrl_if.master       bus,
    output logic                         fault,
    output logic [3:0]                   state_dbg
`ifdef MIPSCTL_PERF_EN
    ,
    output logic [31:0]                  instr_retired,
    output logic [31:0]                  cycle_count
`endif
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, R_WB = 4'd3,
        EXEC_I = 4'd4, I_WB = 4'd5, MEM_ADDR = 4'd6, MEM_RD = 4'd7,
        MEM_WB = 4'd8, MEM_WR = 4'd9, BRANCH = 4'd10, JUMP = 4'd11,
        HALT = 4'd15
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04,
                           OP_J = 6'h02, OP_ADDI = 6'h08, OP_ANDI = 6'h0c, OP_ORI = 6'h0d;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011;
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_nx;
    logic [7:0] tcnt, tcnt_nx;
    logic       fault_q, fault_nx;
    logic       wait_st;

    assign wait_st = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

    // All outputs are forced low while rst_n is held, regardless of state.
    always_comb begin
        state_nx          = state;
        tcnt_nx           = '0;
        fault_nx          = fault_q;
        bus.alucon        = ALU_ADD;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_src        = 2'd0;
        bus.ir_write      = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        fault             = 1'b0;
        state_dbg         = 4'd0;
        if (rst_n) begin
            fault     = fault_q;
            state_dbg = state;
            case (state)
                FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'd1;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_nx     = DECODE;
                    end
                end
                DECODE: begin
                    bus.alu_src_b = 2'd3;
                    case (bus.op)
                        OP_R:                      state_nx = EXEC_R;
                        OP_LW, OP_SW:              state_nx = MEM_ADDR;
                        OP_BEQ:                    state_nx = BRANCH;
                        OP_J:                      state_nx = JUMP;
                        OP_ADDI, OP_ANDI, OP_ORI:  state_nx = EXEC_I;
                        default:                   state_nx = HALT;
                    endcase
                end
                EXEC_R: begin
                    bus.alu_src_a = 1'b1;
                    state_nx      = R_WB;
                    case (bus.funct)
                        F_ADD:   bus.alucon = ALU_ADD;
                        F_SUB:   bus.alucon = ALU_SUB;
                        F_AND:   bus.alucon = ALU_AND;
                        F_OR:    bus.alucon = ALU_OR;
                        default: state_nx   = HALT;
                    endcase
                end
                R_WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                    state_nx      = FETCH;
                end
                EXEC_I: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                    state_nx      = I_WB;
                    case (bus.op)
                        OP_ANDI: bus.alucon = ALU_AND;
                        OP_ORI:  bus.alucon = ALU_OR;
                        default: bus.alucon = ALU_ADD;
                    endcase
                end
                I_WB: begin
                    bus.reg_write = 1'b1;
                    state_nx      = FETCH;
                end
                MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                    state_nx      = (bus.op == OP_SW) ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                    if (bus.mem_ready) state_nx = MEM_WB;
                end
                MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    state_nx       = FETCH;
                end
                MEM_WR: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                    if (bus.mem_ready) state_nx = FETCH;
                end
                BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alucon        = ALU_SUB;
                    bus.pc_src        = 2'd1;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_write      = bus.zero;
                    state_nx          = FETCH;
                end
                JUMP: begin
                    bus.pc_src   = 2'd2;
                    bus.pc_write = 1'b1;
                    state_nx     = FETCH;
                end
                HALT:    state_nx = HALT;
                default: state_nx = HALT;
            endcase
            // Wait counter runs only while a memory state is stalled.
            if (wait_st && !bus.mem_ready) begin
                tcnt_nx = tcnt + 8'd1;
                if (tcnt == TO_LAST) state_nx = HALT;
            end
            if (state_nx == HALT) fault_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH;
            tcnt    <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nx;
            tcnt    <= tcnt_nx;
            fault_q <= fault_nx;
        end
    end

`ifdef MIPSCTL_PERF_EN
    logic [31:0] ret_q, cyc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ret_q <= '0;
            cyc_q <= '0;
        end else begin
            if (state != HALT) cyc_q <= cyc_q + 32'd1;
            if (state_nx == FETCH && state != FETCH) ret_q <= ret_q + 32'd1;
        end
    end

    assign instr_retired = rst_n ? ret_q : 32'd0;
    assign cycle_count   = rst_n ? cyc_q : 32'd0;
`endif
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-stepped bench: per-instruction expected state paths built from queues,
// expected control vector per state taken from the state/output table.
module tb_mips_multicycle_ctrl;
    localparam int TO = 4;
    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04,
                           OP_J = 6'h02, OP_ADDI = 6'h08, OP_ANDI = 6'h0c, OP_ORI = 6'h0d;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fault;
    logic [3:0] state_dbg;
    int n_tests = 0;
    int n_fail = 0;
    int m_cyc = 0;
    int m_ret = 0;
    int q_st[$];
    bit q_rdy[$];

    mips_multicycle_ctrl_if bus();

`ifdef MIPSCTL_PERF_EN
    logic [31:0] instr_retired, cycle_count;
    mips_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .fault(fault), .state_dbg(state_dbg),
        .instr_retired(instr_retired), .cycle_count(cycle_count));
`else
    mips_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .fault(fault), .state_dbg(state_dbg));
`endif

    always #5 clk = ~clk;

    logic [21:0] got;
    assign got = {state_dbg, bus.alucon, bus.alu_src_a, bus.alu_src_b, bus.pc_write,
                  bus.pc_write_cond, bus.pc_src, bus.ir_write, bus.iord, bus.mem_read,
                  bus.mem_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg, fault};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20: return 3'b000;
            6'h22: return 3'b001;
            6'h24: return 3'b010;
            6'h25: return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit r_legal(input logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25;
    endfunction

    function automatic logic [21:0] exp_vec(input int s, input logic [5:0] op, input logic [5:0] fn,
                                            input logic z, input logic rdy);
        logic [2:0] ac = 3'd0;
        logic sa = 1'b0, pw = 1'b0, pwc = 1'b0, irw = 1'b0, io = 1'b0, mr = 1'b0;
        logic mw = 1'b0, rw = 1'b0, rd = 1'b0, m2r = 1'b0, f = 1'b0;
        logic [1:0] sb = 2'd0, ps = 2'd0;
        case (s)
            0:  begin mr = 1; sb = 1; irw = rdy; pw = rdy; end
            1:  sb = 3;
            2:  begin sa = 1; ac = r_alu(fn); end
            3:  begin rw = 1; rd = 1; end
            4:  begin sa = 1; sb = 2; ac = (op == OP_ANDI) ? 3'b010 : (op == OP_ORI) ? 3'b011 : 3'b000; end
            5:  rw = 1;
            6:  begin sa = 1; sb = 2; end
            7:  begin mr = 1; io = 1; end
            8:  begin rw = 1; m2r = 1; end
            9:  begin mw = 1; io = 1; end
            10: begin sa = 1; ac = 3'b001; ps = 1; pwc = 1; pw = z; end
            11: begin ps = 2; pw = 1; end
            default: f = 1;
        endcase
        return {4'(s), ac, sa, sb, pw, pwc, ps, irw, io, mr, mw, rw, rd, m2r, f};
    endfunction

    function automatic void push1(input int s, input bit r);
        q_st.push_back(s);
        q_rdy.push_back(r);
    endfunction

    // w stall cycles in state s, then ready; w >= TO ends in HALT instead.
    function automatic bit push_wait(input int s, input int w);
        for (int i = 0; i < w && i < TO; i++) push1(s, 1'b0);
        if (w >= TO) begin
            push1(15, 1'b0);
            return 1'b1;
        end
        push1(s, 1'b1);
        return 1'b0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.mem_ready = 1'($urandom);
        #1;
        chk("reset_outputs", 32'(got), 32'd0);
`ifdef MIPSCTL_PERF_EN
        chk("reset_cyc", cycle_count, 32'd0);
        chk("reset_ret", instr_retired, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_cyc = 0;
        m_ret = 0;
    endtask

    task automatic run_instr(input logic [5:0] op_i, input logic [5:0] fn_i, input logic z_i,
                             input int fw, input int mw, input int cut);
        bit halted;
        q_st.delete();
        q_rdy.delete();
        if (!push_wait(0, fw)) begin
            push1(1, 1'b0);
            case (op_i)
                OP_R:   begin push1(2, 1'b0); push1(r_legal(fn_i) ? 3 : 15, 1'b0); end
                OP_LW:  begin push1(6, 1'b0); if (!push_wait(7, mw)) push1(8, 1'b0); end
                OP_SW:  begin push1(6, 1'b0); void'(push_wait(9, mw)); end
                OP_BEQ: push1(10, 1'b0);
                OP_J:   push1(11, 1'b0);
                OP_ADDI, OP_ANDI, OP_ORI: begin push1(4, 1'b0); push1(5, 1'b0); end
                default: push1(15, 1'b0);
            endcase
        end
        halted = (q_st[q_st.size()-1] == 15);
        if (halted) begin push1(15, 1'b0); push1(15, 1'b0); end
        for (int i = 0; i < q_st.size(); i++) begin
            int s;
            s = q_st[i];
            @(negedge clk);
            bus.op = op_i;
            bus.funct = fn_i;
            bus.zero = z_i;
            bus.mem_ready = (s == 0 || s == 7 || s == 9) ? q_rdy[i] : 1'($urandom);
            #1;
            chk($sformatf("op%0h_st%0d", op_i, s), 32'(got),
                32'(exp_vec(s, op_i, fn_i, z_i, bus.mem_ready)));
`ifdef MIPSCTL_PERF_EN
            chk("cycle_count", cycle_count, 32'(m_cyc));
            chk("instr_retired", instr_retired, 32'(m_ret));
`endif
            if (s != 15) m_cyc++;
            if (cut >= 0 && i + 1 >= cut) return;
            if (i == q_st.size() - 1 && s != 15) m_ret++;
        end
        if (halted) do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] rf[4];
        logic [5:0] iops[3];
        logic [5:0] bad[4];
        rf = '{6'h20, 6'h22, 6'h24, 6'h25};
        iops = '{OP_ADDI, OP_ANDI, OP_ORI};
        bad = '{6'h01, 6'h05, 6'h3f, 6'h0f};
        bus.op = '0;
        bus.funct = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        do_reset();
        run_instr(OP_R, 6'h22, 1'b0, 0, 0, -1);
        run_instr(OP_LW, 6'h00, 1'b0, 0, 3, -1);
        run_instr(OP_BEQ, 6'h00, 1'b1, 0, 0, -1);
        run_instr(OP_BEQ, 6'h00, 1'b0, 1, 0, -1);
        run_instr(OP_ORI, 6'h3f, 1'b0, 0, 0, -1);
        run_instr(OP_J, 6'h00, 1'b0, 3, 0, -1);
        run_instr(OP_R, 6'h2a, 1'b0, 0, 0, -1);
        run_instr(OP_ADDI, 6'h00, 1'b0, TO, 0, -1);
        run_instr(OP_LW, 6'h00, 1'b0, 0, TO, -1);
        run_instr(OP_SW, 6'h00, 1'b0, 0, 3, -1);
        run_instr(6'h3e, 6'h20, 1'b0, 0, 0, -1);
        // abandon a store mid-stall, then the next check sees a clean FETCH
        run_instr(OP_SW, 6'h00, 1'b0, 0, 3, 4);
        do_reset();
        for (int k = 0; k < 3; k++) run_instr(OP_R, 6'h20, 1'b0, 0, 0, -1);
`ifdef MIPSCTL_PERF_EN
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("perf_3r_ret", instr_retired, 32'd3);
        chk("perf_3r_cyc", cycle_count, 32'd12);
`endif
        do_reset();
        for (int k = 0; k < 40; k++) begin
            int c;
            logic [5:0] fn;
            c = $urandom_range(0, 7);
            fn = 6'($urandom);
            case (c)
                0: run_instr(OP_R, rf[$urandom_range(0, 3)], 1'b0, $urandom_range(0, 3), 0, -1);
                1: run_instr(iops[$urandom_range(0, 2)], fn, 1'b0, $urandom_range(0, 3), 0, -1);
                2: run_instr(OP_LW, fn, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3), -1);
                3: run_instr(OP_SW, fn, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3), -1);
                4: run_instr(OP_BEQ, fn, 1'($urandom), $urandom_range(0, 3), 0, -1);
                5: run_instr(OP_J, fn, 1'($urandom), $urandom_range(0, 3), 0, -1);
                6: run_instr(bad[$urandom_range(0, 3)], fn, 1'b0, 0, 0, -1);
                default: run_instr(OP_R, fn, 1'b0, $urandom_range(0, 3), 0, -1);
            endcase
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle MIPS control FSM. It is the initiator that drives the 32-bit ALU's `alucon` select (add=000, sub=001, AND=010, OR=011) and all datapath enables, one instruction at a time.
- Sits between the instruction register / memory port and the datapath; the ALU is purely combinational, so all sequencing lives here.
- Handshakes with a variable-latency memory through `mem_ready`.

Parameters:
- MEM_TIMEOUT, 255: max cycles spent waiting on `mem_ready` before `fault` is raised; range 1..255, 8-bit counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- op  in  6  opcode field of the instruction register
- funct  in  6  funct field of the instruction register
- zero  in  1  asserted when the current ALU result is 0 (used for beq)
- mem_ready  in  1  memory completes the current read or write this cycle
- alucon  out  3  ALU operation select
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate shifted left 2
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if `zero` (controller gates internally onto pc_write)
- pc_src  out  2  0 = ALU result, 1 = ALUOut register, 2 = jump target
- ir_write  out  1  load instruction register
- iord  out  1  0 = PC address, 1 = ALUOut address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- fault  out  1  sticky: illegal opcode/funct or memory timeout
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: `rst_n` is sampled on the rising edge of `clk` (synchronous, active-low). Low forces state = FETCH, clears `fault` and the timeout counter. While `rst_n` is low, every output is 0 except `state_dbg` = 0. Reset mid-instruction abandons the instruction with no writes.
- Outputs are a Moore decode of state. Exception: the write strobes `ir_write`, `pc_write`, `reg_write` in memory states are additionally gated by `mem_ready`.
- Unused outputs are 0 in each state. `alucon` defaults to 000.
- State encoding and behaviour:
  - FETCH (0): `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alucon`=add, `pc_src`=0. On `mem_ready`: `ir_write`=1, `pc_write`=1, go to DECODE. Otherwise stay.
  - DECODE (1): `alu_src_a`=0, `alu_src_b`=3, `alucon`=add (branch target into ALUOut). Next state by op:
    - 000000 -> EXEC_R
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000, 001100, 001101 -> EXEC_I
    - else -> HALT with `fault`=1
  - EXEC_R (2): `alu_src_a`=1, `alu_src_b`=0. `alucon` from funct: 100000 -> add, 100010 -> sub, 100100 -> AND, 100101 -> OR. Any other funct -> HALT with `fault`=1. Otherwise -> R_WB.
  - R_WB (3): `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0 -> FETCH.
  - EXEC_I (4): `alu_src_a`=1, `alu_src_b`=2. `alucon` = add for addi, AND for andi, OR for ori -> I_WB.
  - I_WB (5): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 -> FETCH.
  - MEM_ADDR (6): `alu_src_a`=1, `alu_src_b`=2, `alucon`=add. lw -> MEM_RD; sw -> MEM_WR.
  - MEM_RD (7): `mem_read`=1, `iord`=1. On `mem_ready` -> MEM_WB.
  - MEM_WB (8): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1 -> FETCH.
  - MEM_WR (9): `mem_write`=1, `iord`=1. On `mem_ready` -> FETCH.
  - BRANCH (10): `alu_src_a`=1, `alu_src_b`=0, `alucon`=sub, `pc_src`=1, `pc_write_cond`=1. `pc_write` = `zero` -> FETCH.
  - JUMP (11): `pc_src`=2, `pc_write`=1 -> FETCH.
  - HALT (15): all outputs 0, `fault`=1. Leaves only on reset.
- Latency in cycles, with zero-wait memory: R/I = 4, lw = 5, sw = 4, beq = 3, j = 3. Each memory wait cycle adds 1.
- Timeout: an 8-bit counter increments each cycle spent in FETCH, MEM_RD or MEM_WR without `mem_ready`, and clears on leaving those states. Reaching MEM_TIMEOUT -> HALT, `fault`=1.
- `mem_ready` arriving outside a memory state is ignored.
- The ALU carry-in is internal to the ALU (sub implies a carry-in of 1); the controller never drives it.

Optional Feature:
- MIPSCTL_PERF_EN: when defined, adds ports `instr_retired` (out, 32) and `cycle_count` (out, 32).
  - Both are 0 on reset.
  - `cycle_count` increments every non-reset cycle except in HALT.
  - `instr_retired` increments on each transition into FETCH from a completing state.
  - Both wrap 0xFFFFFFFF -> 0.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then op=000000, funct=100010 (sub), `mem_ready` tied 1 -> states 0,1,2,3,0; `alucon`=001 in EXEC_R; `reg_write`=1, `reg_dst`=1 only in R_WB.
- lw (op=100011) with `mem_ready` low 3 cycles in MEM_RD -> `mem_read`=1, `iord`=1 held; MEM_WB reached exactly one cycle after `mem_ready`; `mem_to_reg`=1; total 8 cycles.
- beq (op=000100) with `zero`=1, then again with `zero`=0 -> `pc_write` high in BRANCH only for the `zero`=1 case; `alucon`=001; `pc_src`=1.
- ori (op=001101) -> `alucon`=011 in EXEC_I, `reg_dst`=0; funct=101010 R-type -> HALT, `fault`=1; only `rst_n` low for 1 cycle clears it.
- MEM_TIMEOUT=4, `mem_ready` held 0 in FETCH -> HALT after 4 cycles, `fault`=1. Separately, drop `rst_n` during MEM_WR -> next cycle state=FETCH, `mem_write`=0.
- With MIPSCTL_PERF_EN defined: 3 back-to-back zero-wait R-types -> `instr_retired`=3, `cycle_count`=12.
